cam_power_seq: RTL

//   Camera power/reset sequencer on the clk domain released by the system reset block.

---
 rtl/cam_power_seq.sv | 90 +++++++++
 1 files changed

// File: rtl/cam_power_seq.sv
// OV5640 power/reset sequencer: orders PWDN and RESETB on power-up and
// power-down, and flags when the sensor is ready for SCCB init.
module cam_power_seq #(
  parameter int CNT_W  = 21,
  parameter int T_PWDN = 50_000,
  parameter int T_RST  = 50_000,
  parameter int T_INIT = 1_000_000,
  parameter int T_DOWN = 5_000
) (
  input  logic clk,
  input  logic rst,
  input  logic pwr_en,
  output logic cam_pwdn,
  output logic cam_rst_n,
  output logic cam_ready,
  output logic busy,
  output logic up_done,
  output logic down_done
);

  typedef enum logic [2:0] {
    OFF,
    PWDN_WAIT,
    RST_WAIT,
    INIT_WAIT,
    ON,
    DOWN_RST
  } state_t;

  localparam logic [CNT_W-1:0] LAST_PWDN = CNT_W'(T_PWDN - 1);
  localparam logic [CNT_W-1:0] LAST_RST  = CNT_W'(T_RST - 1);
  localparam logic [CNT_W-1:0] LAST_INIT = CNT_W'(T_INIT - 1);
  localparam logic [CNT_W-1:0] LAST_DOWN = CNT_W'(T_DOWN - 1);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic             timed;

  // Abort on pwr_en=0 is checked before the timer so it wins a tie.
  always_comb begin
    nxt = state;
    case (state)
      OFF:
        if (pwr_en) nxt = PWDN_WAIT;
      PWDN_WAIT:
        if (!pwr_en) nxt = OFF;
        else if (cnt == LAST_PWDN) nxt = RST_WAIT;
      RST_WAIT:
        if (!pwr_en) nxt = DOWN_RST;
        else if (cnt == LAST_RST) nxt = INIT_WAIT;
      INIT_WAIT:
        if (!pwr_en) nxt = DOWN_RST;
        else if (cnt == LAST_INIT) nxt = ON;
      ON:
        if (!pwr_en) nxt = DOWN_RST;
      DOWN_RST:
        if (cnt == LAST_DOWN) nxt = OFF;
      default:
        nxt = OFF;
    endcase
  end

  assign timed = (state != OFF) && (state != ON);

  // Pins are decoded from nxt so they move on the same edge as state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= OFF;
      cnt       <= '0;
      cam_pwdn  <= 1'b1;
      cam_rst_n <= 1'b0;
      cam_ready <= 1'b0;
      busy      <= 1'b0;
      up_done   <= 1'b0;
      down_done <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt != state) cnt <= '0;
      else if (timed)   cnt <= cnt + 1'b1;
      cam_pwdn  <= (nxt == OFF) || (nxt == PWDN_WAIT);
      cam_rst_n <= (nxt == INIT_WAIT) || (nxt == ON);
      cam_ready <= (nxt == ON);
      busy      <= (nxt != OFF) && (nxt != ON);
      up_done   <= (nxt == ON) && (state != ON);
      down_done <= (nxt == OFF) && (state != OFF);
    end
  end

endmodule
